// File: rtl/serdesphy_rx_pkg.sv
// Shared types and constants for the RX deserializer/aligner: FSM encoding,
// default alignment pattern and counter widths.
package serdesphy_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HUNT    = 2'd1,
        ST_CONFIRM = 2'd2,
        ST_LOCKED  = 2'd3
    } rx_state_e;

    localparam logic [15:0] DEFAULT_SYNC_WORD = 16'hF0A5;

    // Wide enough for SD_DEBOUNCE up to 15 and LOCK_MATCHES up to 7.
    localparam int SD_CNT_W    = 4;
    localparam int MATCH_CNT_W = 3;
    localparam int LOSS_CNT_W  = 8;

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serdesphy_rx_deserializer_aligner_if.sv
// Receiver-side bundle: serial bit stream and control in, aligned parallel
// words and link status out.
interface serdesphy_rx_deserializer_aligner_if #(
    parameter int WORD_WIDTH = 16
);
    logic                  enable;
    logic                  resync;
    logic                  serial_data;
    logic                  signal_detected;
    logic [WORD_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_is_sync;
    logic                  sd_qualified;
    logic                  locked;
    logic [7:0]            lock_loss_cnt;

    // Driver side: differential receiver / link controller.
    modport master (
        output enable, resync, serial_data, signal_detected,
        input  rx_data, rx_valid, rx_is_sync, sd_qualified, locked, lock_loss_cnt
    );

    // Deserializer side.
    modport slave (
        input  enable, resync, serial_data, signal_detected,
        output rx_data, rx_valid, rx_is_sync, sd_qualified, locked, lock_loss_cnt
    );
endinterface

// File: rtl/serdesphy_rx_sd_debounce.sv
// Signal-detect qualifier: the raw flag must stay high for SD_DEBOUNCE
// consecutive cycles; any low cycle restarts the count.
module serdesphy_rx_sd_debounce
    import serdesphy_rx_pkg::*;
#(
    parameter int SD_DEBOUNCE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic signal_detected_i,
    output logic sd_qualified_o
);

    localparam logic [SD_CNT_W-1:0] SD_MAX = SD_CNT_W'(SD_DEBOUNCE);

    logic [SD_CNT_W-1:0] sd_cnt_q, sd_cnt_d;
    logic                sd_qualified_q;

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        sd_cnt_d = sd_cnt_q;
        if (!signal_detected_i) begin
            sd_cnt_d = '0;
        end else if (sd_cnt_q != SD_MAX) begin
            sd_cnt_d = sd_cnt_q + SD_CNT_W'(1);
        end
    end

    // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sd_cnt_q       <= '0;
            sd_qualified_q <= 1'b0;
        end else begin
            sd_cnt_q       <= sd_cnt_d;
            sd_qualified_q <= (sd_cnt_q == SD_MAX);
        end
    end

    assign sd_qualified_o = sd_qualified_q;

endmodule

// File: rtl/serdesphy_rx_deserializer_aligner.sv
// RX deserializer: shifts the serial stream MSB-first, hunts for the sync
// word at any bit offset, confirms alignment, then emits parallel words.
module serdesphy_rx_deserializer_aligner
    import serdesphy_rx_pkg::*;
#(
    parameter int                    WORD_WIDTH   = 16,
    parameter logic [WORD_WIDTH-1:0] SYNC_WORD    = WORD_WIDTH'(DEFAULT_SYNC_WORD),
    parameter int                    SD_DEBOUNCE  = 4,
    parameter int                    LOCK_MATCHES = 2
) (
    input logic clk,
    input logic rst,
    serdesphy_rx_deserializer_aligner_if.slave rx_if
);

    localparam int                     BIT_CNT_W = cnt_width(WORD_WIDTH);
    localparam logic [BIT_CNT_W-1:0]   BIT_LAST  = BIT_CNT_W'(WORD_WIDTH - 1);
    localparam logic [MATCH_CNT_W-1:0] MATCH_TGT = MATCH_CNT_W'(LOCK_MATCHES);

    rx_state_e               state_q, state_d;
    logic [WORD_WIDTH-1:0]   shreg_q, shreg_nx;
    logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [MATCH_CNT_W-1:0]  match_cnt_q, match_cnt_d, match_inc;
    logic [WORD_WIDTH-1:0]   rx_data_q, rx_data_d;
    logic                    rx_valid_q, rx_valid_d;
    logic                    rx_is_sync_q, rx_is_sync_d;
    logic                    locked_q, locked_d;
    logic [LOSS_CNT_W-1:0]   lock_loss_q, lock_loss_d;
    logic                    sd_qualified;
    logic                    run;
    logic                    sync_hit;
    logic                    emit;

    serdesphy_rx_sd_debounce #(
        .SD_DEBOUNCE (SD_DEBOUNCE)
    ) u_sd_debounce (
        .clk               (clk),
        .rst               (rst),
        .signal_detected_i (rx_if.signal_detected),
        .sd_qualified_o    (sd_qualified)
    );

    assign run       = rx_if.enable && sd_qualified;
    assign shreg_nx  = run ? {shreg_q[WORD_WIDTH-2:0], rx_if.serial_data} : '0;
    assign sync_hit  = (shreg_nx == SYNC_WORD);
    assign match_inc = match_cnt_q + MATCH_CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            match_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_nx;
            bit_cnt_q   <= bit_cnt_d;
            match_cnt_q <= match_cnt_d;
        end
    end

    // Losing enable/signal outranks resync, so a coincident pair lands in IDLE.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        match_cnt_d = match_cnt_q;
        if (!run) begin
            state_d     = ST_IDLE;
            bit_cnt_d   = '0;
            match_cnt_d = '0;
        end else if (rx_if.resync && (state_q != ST_IDLE)) begin
            state_d     = ST_HUNT;
            bit_cnt_d   = '0;
            match_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_HUNT;
                ST_HUNT: begin
                    if (sync_hit) begin
                        bit_cnt_d   = '0;
                        match_cnt_d = MATCH_CNT_W'(1);
                        state_d     = (LOCK_MATCHES == 1) ? ST_LOCKED : ST_CONFIRM;
                    end
                end
                ST_CONFIRM: begin
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        if (sync_hit) begin
                            match_cnt_d = match_inc;
                            if (match_inc == MATCH_TGT) begin
                                state_d = ST_LOCKED;
                            end
                        end else begin
                            match_cnt_d = '0;
                            state_d     = ST_HUNT;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
                ST_LOCKED: begin
                    bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BIT_CNT_W'(1);
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // LOCKED only persists when no exit fired, so state_d doubles as the "still locked" test.
    assign emit = (state_q == ST_LOCKED) && (state_d == ST_LOCKED) && (bit_cnt_q == BIT_LAST);

    always_comb begin
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        rx_is_sync_d = 1'b0;
        locked_d     = (state_d == ST_LOCKED);
        lock_loss_d  = lock_loss_q;
        if (emit) begin
            rx_data_d    = shreg_nx;
            rx_valid_d   = 1'b1;
            rx_is_sync_d = sync_hit;
        end
        if ((state_q == ST_LOCKED) && (state_d != ST_LOCKED) && (lock_loss_q != '1)) begin
            lock_loss_d = lock_loss_q + LOSS_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            rx_is_sync_q <= 1'b0;
            locked_q     <= 1'b0;
            lock_loss_q  <= '0;
        end else begin
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            rx_is_sync_q <= rx_is_sync_d;
            locked_q     <= locked_d;
            lock_loss_q  <= lock_loss_d;
        end
    end

    assign rx_if.rx_data       = rx_data_q;
    assign rx_if.rx_valid      = rx_valid_q;
    assign rx_if.rx_is_sync    = rx_is_sync_q;
    assign rx_if.sd_qualified  = sd_qualified;
    assign rx_if.locked        = locked_q;
    assign rx_if.lock_loss_cnt = lock_loss_q;

endmodule
